// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the time-multiplexed switch debouncer.
package debounce_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } dbnc_state_t;

    // Counter must hold STABLE_CNT-1; one spare code keeps STABLE_CNT=1 at 1 bit.
    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbnc_tick_gen.sv
// Sample-tick prescaler: one-cycle tick every PRESCALE clocks while enabled.
module dbnc_tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk50m,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debouncer: one shared compare/update path serves all channels,
// visiting each channel once per sample tick.
//
// state  | meaning
// S_IDLE | waiting for the next sample tick
// S_SCAN | updating channel scan_ch, one channel per clock
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PRESCALE   = 50000,
    parameter int STABLE_CNT = 8
) (
    input  logic                       clk50m,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_CH-1:0]            sw,
    output logic [N_CH-1:0]            sw_dbnc,
    output logic [N_CH-1:0]            sw_hi,
    output logic [N_CH-1:0]            sw_lo,
    output logic                       scan_busy,
    output logic [idx_width(N_CH)-1:0] scan_ch
);

    localparam int CNT_W = cnt_width(STABLE_CNT);
    localparam int CH_W  = idx_width(N_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    if (PRESCALE <= N_CH) begin : g_param_chk
        $fatal(1, "debounce_scan_ctrl: PRESCALE must exceed N_CH");
    end

    logic [N_CH-1:0]  sw_meta;
    logic [N_CH-1:0]  sw_s;
    logic [CNT_W-1:0] cnt [N_CH];
    dbnc_state_t      state;
    logic             tick;
    logic             samp;
    logic             level;

    dbnc_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk50m (clk50m),
        .rst    (rst),
        .en     (en),
        .tick   (tick)
    );

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    // A scan always runs to completion; en only gates the launch via tick.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            scan_ch <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state   <= S_SCAN;
                        scan_ch <= '0;
                    end
                end
                S_SCAN: begin
                    if (scan_ch == CH_LAST) begin
                        state   <= S_IDLE;
                        scan_ch <= '0;
                    end else begin
                        scan_ch <= scan_ch + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    scan_ch <= '0;
                end
            endcase
        end
    end

    assign scan_busy = (state == S_SCAN);
    assign samp      = sw_s[scan_ch];
    assign level     = sw_dbnc[scan_ch];

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            sw_dbnc <= '0;
            sw_hi   <= '0;
            sw_lo   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_hi <= '0;
            sw_lo <= '0;
            if (state == S_SCAN) begin
                if (samp == level) begin
                    cnt[scan_ch] <= '0;
                end else if (cnt[scan_ch] == CNT_LAST) begin
                    sw_dbnc[scan_ch] <= samp;
                    sw_hi[scan_ch]   <= samp;
                    sw_lo[scan_ch]   <= ~samp;
                    cnt[scan_ch]     <= '0;
                end else begin
                    cnt[scan_ch] <= cnt[scan_ch] + 1'b1;
                end
            end
        end
    end

endmodule
